// File: rtl/activation_row_writer.sv
// activation_row_writer
// Takes a raster stream of signed conv accumulators, applies an arithmetic shift
// followed by ReLU or saturation, and writes each row into one bank of the banked
// feature RAM read by the max-pool stage. Row y goes to bank (y mod NUM_RAM_SPLITS)
// at address x. A per-bank credit count stops a row that the pooler has not yet
// released from being overwritten.
module activation_row_writer #(
  parameter int INPUT_X        = 128,
  parameter int INPUT_Y        = 128,
  parameter int ACC_WIDTH      = 32,
  parameter int BIT_WIDTH      = 16,
  parameter int SHIFT          = 8,
  parameter int RELU           = 1,
  parameter int NUM_RAM_SPLITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ACC_WIDTH-1:0]       in_data,
  input  logic                       row_release,
  output logic [BIT_WIDTH-1:0]       data_wr,
  output logic [$clog2(INPUT_X)-1:0] addr_wr,
  output logic [NUM_RAM_SPLITS-1:0]  wren,
  output logic                       row_done,
  output logic [((NUM_RAM_SPLITS > 1) ? $clog2(NUM_RAM_SPLITS) : 1)-1:0] row_bank,
  output logic                       done
);

  localparam int XW = $clog2(INPUT_X);
  localparam int YW = (INPUT_Y > 1) ? $clog2(INPUT_Y) : 1;
  localparam int BW = (NUM_RAM_SPLITS > 1) ? $clog2(NUM_RAM_SPLITS) : 1;
  localparam int CW = $clog2(NUM_RAM_SPLITS + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(INPUT_X - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(INPUT_Y - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(NUM_RAM_SPLITS - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(NUM_RAM_SPLITS);

  // Largest / smallest representable output value, sign-extended to the input width
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] bank;
  logic [CW-1:0] credits;

  logic accept;
  logic row_end;
  logic last_sample;
  logic start_frame;

  // Shift, then ReLU or saturate into the output word width
  function automatic logic [BIT_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> SHIFT;
    if (s < 0) begin
      if (RELU != 0) begin
        clamp = '0;
      end else if (s < OUT_MIN) begin
        clamp = OUT_MIN[BIT_WIDTH-1:0];
      end else begin
        clamp = s[BIT_WIDTH-1:0];
      end
    end else if (s > OUT_MAX) begin
      clamp = OUT_MAX[BIT_WIDTH-1:0];
    end else begin
      clamp = s[BIT_WIDTH-1:0];
    end
  endfunction

  assign in_ready    = (state == RUN) && (credits != '0);
  assign accept      = in_valid && in_ready;
  assign row_end     = accept && (x == X_LAST);
  assign last_sample = row_end && (y == Y_LAST);
  assign start_frame = start && ((state == IDLE) || (state == DONE));

  // Frame FSM, raster counters, bank credits and the registered RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      bank     <= '0;
      credits  <= CRED_MAX;
      data_wr  <= '0;
      addr_wr  <= '0;
      wren     <= '0;
      row_done <= 1'b0;
      row_bank <= '0;
      done     <= 1'b0;
    end else begin
      wren     <= '0;
      row_done <= 1'b0;

      if (start_frame) begin
        credits <= CRED_MAX;
      end else if (row_end && !row_release) begin
        credits <= credits - CW'(1);
      end else if (!row_end && row_release && (credits != CRED_MAX)) begin
        credits <= credits + CW'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            x     <= '0;
            y     <= '0;
            bank  <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            wren    <= NUM_RAM_SPLITS'(1) << bank;
            addr_wr <= x;
            data_wr <= clamp(in_data);
            if (row_end) begin
              x        <= '0;
              y        <= y + YW'(1);
              bank     <= (bank == BANK_LAST) ? '0 : bank + BW'(1);
              row_done <= 1'b1;
              row_bank <= bank;
              if (last_sample) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_row_writer.sv
// tb_activation_row_writer
// Directed sequence with randomized data / valid / release patterns. Expected
// outputs come from a sample-index model: sample k of a frame lands in row k/X,
// column k%X, bank (k/X)%NS, with credits = min(NS, credits - rows_finished + releases).
module tb_activation_row_writer;

  localparam int X  = 4;
  localparam int Y  = 4;
  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        row_release;
  logic [31:0] in_data;

  logic        in_ready, in_ready2;
  logic [15:0] data_wr, data_wr2;
  logic [1:0]  addr_wr, addr_wr2;
  logic [1:0]  wren, wren2;
  logic        row_done, row_done2;
  logic        row_bank, row_bank2;
  logic        done, done2;

  always #5 clk = ~clk;

  activation_row_writer #(
    .INPUT_X(X), .INPUT_Y(Y), .ACC_WIDTH(32), .BIT_WIDTH(16),
    .SHIFT(8), .RELU(1), .NUM_RAM_SPLITS(NS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .row_release(row_release), .data_wr(data_wr), .addr_wr(addr_wr),
    .wren(wren), .row_done(row_done), .row_bank(row_bank), .done(done)
  );

  activation_row_writer #(
    .INPUT_X(X), .INPUT_Y(Y), .ACC_WIDTH(32), .BIT_WIDTH(16),
    .SHIFT(8), .RELU(0), .NUM_RAM_SPLITS(NS)
  ) dut_relu0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .row_release(row_release), .data_wr(data_wr2), .addr_wr(addr_wr2),
    .wren(wren2), .row_done(row_done2), .row_bank(row_bank2), .done(done2)
  );

  int testCount = 0;
  int failCount = 0;

  bit          mRun = 0;
  bit          mDone = 0;
  int          mIdx = 0;
  int          mCredits = NS;
  logic [1:0]  expWren = '0;
  bit          expRowDone = 0;
  bit          expZero = 0;
  int          expAddr = 0;
  int          expBank = 0;
  logic [15:0] expData = '0;
  logic [15:0] expData2 = '0;
  int          obsAccepts = 0;
  int          obsRowDones = 0;
  bit [1:0]    rdHist = '0;

  function automatic logic [15:0] refClamp(input logic [31:0] d, input bit relu);
    longint s;
    s = longint'($signed(d));
    s = (s - (((s % 256) + 256) % 256)) / 256;
    if (s < 0) begin
      if (relu) return 16'h0000;
      if (s < -32768) return 16'h8000;
      return 16'(s);
    end
    if (s > 32767) return 16'h7FFF;
    return 16'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    if (row_done === 1'b1) obsRowDones++;
    check("in_ready", 32'(in_ready), 32'(mRun && (mCredits != 0)));
    check("wren", 32'(wren), 32'(expWren));
    check("row_done", 32'(row_done), 32'(expRowDone));
    check("done", 32'(done), 32'(mDone));
    check("relu0_in_ready", 32'(in_ready2), 32'(mRun && (mCredits != 0)));
    check("relu0_wren", 32'(wren2), 32'(expWren));
    check("relu0_done", 32'(done2), 32'(mDone));
    if (expWren != '0) begin
      check("addr_wr", 32'(addr_wr), 32'(expAddr));
      check("data_wr", 32'(data_wr), 32'(expData));
      check("relu0_addr_wr", 32'(addr_wr2), 32'(expAddr));
      check("relu0_data_wr", 32'(data_wr2), 32'(expData2));
    end
    if (expRowDone) begin
      check("row_bank", 32'(row_bank), 32'(expBank));
      check("relu0_row_done", 32'(row_done2), 32'(1));
      check("relu0_row_bank", 32'(row_bank2), 32'(expBank));
    end
    if (expZero) begin
      check("reset_addr_wr", 32'(addr_wr), 32'(0));
      check("reset_data_wr", 32'(data_wr), 32'(0));
      check("reset_row_bank", 32'(row_bank), 32'(0));
    end
  endtask

  // Drives one cycle at a negedge, advances the model, then checks at the next negedge
  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit rel,
                               input bit st, input bit r);
    bit started;
    bit rowEnd;
    int row;
    int col;
    if (v && (in_ready === 1'b1) && !r) obsAccepts++;
    in_valid    = v;
    in_data     = d;
    row_release = rel;
    start       = st;
    rst         = r;
    expWren     = '0;
    expRowDone  = 0;
    expZero     = 0;
    if (r) begin
      mRun     = 0;
      mDone    = 0;
      mIdx     = 0;
      mCredits = NS;
      expZero  = 1;
    end else begin
      started = !mRun && st;
      rowEnd  = 0;
      if (started) begin
        mRun  = 1;
        mDone = 0;
        mIdx  = 0;
      end else if (v && mRun && (mCredits != 0)) begin
        row      = mIdx / X;
        col      = mIdx % X;
        expWren  = 2'(1 << (row % NS));
        expAddr  = col;
        expData  = refClamp(d, 1);
        expData2 = refClamp(d, 0);
        if (col == X - 1) begin
          rowEnd     = 1;
          expRowDone = 1;
          expBank    = row % NS;
        end
        mIdx++;
        if (mIdx == X * Y) begin
          mRun  = 0;
          mDone = 1;
        end
      end
      if (started) begin
        mCredits = NS;
      end else begin
        mCredits = mCredits - int'(rowEnd) + int'(rel);
        if (mCredits > NS) mCredits = NS;
      end
    end
    rdHist = {rdHist[0], expRowDone};
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] randData();
    logic [31:0] d;
    d = $urandom;
    if ($urandom_range(0, 1) == 1) d = $signed(d) >>> $urandom_range(8, 24);
    return d;
  endfunction

  // Feeds samples until the model reports the frame finished (bounded)
  task automatic finishFrame(input int gap, input bit noise, input bit rnd, input bit autoRel);
    int cyc;
    bit v;
    bit rel;
    logic [31:0] d;
    cyc = 0;
    while (!mDone && cyc < 400) begin
      v   = (cyc % gap) == 0;
      d   = rnd ? randData() : 32'(mIdx << 8);
      rel = autoRel ? rdHist[1] : ($urandom_range(0, 3) == 0);
      applyStimulus(v, d, rel, noise && ($urandom_range(0, 4) == 0), 0);
      cyc++;
    end
    check("frame_done", 32'(done), 32'(1));
  endtask

  task automatic runFrame(input int gap, input bit noise, input bit rnd, input bit autoRel);
    rdHist = '0;
    applyStimulus(0, 32'h0, 0, 1, 0);
    finishFrame(gap, noise, rnd, autoRel);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    row_release = 1'b0;
    @(negedge clk);

    // Reset state, then valid in IDLE must be ignored
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(1, 32'h100, 0, 0, 0);
    applyStimulus(1, 32'h200, 1, 0, 0);

    // Test 1: clean frame, in_data = k<<8, release two cycles after each row_done
    obsRowDones = 0;
    runFrame(1, 0, 0, 1);
    check("t1_row_done_count", 32'(obsRowDones), 32'(4));

    // Test 2: clamp corners, both RELU settings
    rdHist = '0;
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'hFFFF_FF00, 0, 0, 0);
    check("clamp_neg_relu", 32'(data_wr), 32'h0000);
    applyStimulus(1, 32'h00FF_FFFF, 0, 0, 0);
    check("clamp_pos_sat", 32'(data_wr), 32'h7FFF);
    applyStimulus(1, 32'h007F_FF00, 0, 0, 0);
    check("clamp_pos_max", 32'(data_wr), 32'h7FFF);
    applyStimulus(1, 32'hFF00_0000, 0, 0, 0);
    check("clamp_neg_sat_relu0", 32'(data_wr2), 32'h8000);
    check("clamp_neg_zero_relu1", 32'(data_wr), 32'h0000);
    finishFrame(1, 0, 1, 1);

    // Test 3: back-pressure with no releases, then a single release
    applyStimulus(0, 32'h0, 0, 1, 0);
    obsAccepts = 0;
    repeat (12) applyStimulus(1, randData(), 0, 0, 0);
    check("bp_accepts_two_rows", 32'(obsAccepts), 32'(8));
    obsAccepts = 0;
    applyStimulus(1, randData(), 1, 0, 0);
    repeat (10) applyStimulus(1, randData(), 0, 0, 0);
    check("bp_accepts_after_release", 32'(obsAccepts), 32'(4));
    applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    rdHist = '0;
    finishFrame(1, 0, 1, 1);

    // Test 4: extra releases at full credit, release coincident with row end
    applyStimulus(0, 32'h0, 0, 1, 0);
    repeat (5) applyStimulus(0, 32'h0, 1, 0, 0);
    obsAccepts = 0;
    repeat (3) applyStimulus(1, randData(), 0, 0, 0);
    applyStimulus(1, randData(), 1, 0, 0);
    repeat (12) applyStimulus(1, randData(), 0, 0, 0);
    check("coincident_release_accepts", 32'(obsAccepts), 32'(12));
    applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 0);
    rdHist = '0;
    finishFrame(1, 0, 1, 1);

    // Test 5: reset mid-frame after six accepts
    applyStimulus(0, 32'h0, 0, 1, 0);
    obsAccepts = 0;
    repeat (6) applyStimulus(1, randData(), 0, 0, 0);
    check("rst_pre_accepts", 32'(obsAccepts), 32'(6));
    applyStimulus(1, randData(), 0, 0, 1);
    obsAccepts = 0;
    repeat (3) applyStimulus(1, randData(), 1, 0, 0);
    check("rst_no_accepts", 32'(obsAccepts), 32'(0));
    applyStimulus(0, 32'h0, 0, 1, 0);
    applyStimulus(1, 32'h0000_0500, 0, 0, 0);
    check("rst_restart_addr", 32'(addr_wr), 32'(0));
    check("rst_restart_wren", 32'(wren), 32'h1);
    rdHist = '0;
    finishFrame(1, 0, 1, 1);

    // Test 6: gapped valid with start noise, then restart from DONE with random traffic
    obsRowDones = 0;
    runFrame(3, 1, 0, 1);
    check("t6_row_done_count", 32'(obsRowDones), 32'(4));
    runFrame(1, 0, 1, 0);
    runFrame(2, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
